controller_select_fsm: RTL and testbench

CONTROLLER_SELECT_FSM -- requirements
Module: controller_select_fsm

---
 rtl/controller_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 54 +++++
 rtl/controller_select_fsm.sv | 151 +++++++++++++++
 tb/tb_controller_select_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared definitions for the routing-mode selector.
//   NUM_MODES / MODE_MAX : size of the routing mode space (0..11)
//   OFF_CODE             : value the routing mux drives while blank_out is high
//   state_t              : selector FSM state encoding
//   cnt_width()          : width of a counter holding 0..n-1
//   mode_step()          : modulo-12 step up or down
package controller_pkg;

  localparam int          NUM_MODES = 12;
  localparam int          MODE_MAX  = 11;
  localparam logic [11:0] OFF_CODE  = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BLANK    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] mode_step(input logic [3:0] mode, input logic up);
    logic [3:0] res;
    if (up) res = (mode >= 4'(MODE_MAX)) ? 4'd0 : mode + 4'd1;
    else    res = (mode == 4'd0 || mode > 4'(MODE_MAX)) ? 4'(MODE_MAX) : mode - 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debounce, press pulse.
//   clk_sys   : system clock
//   rst_b     : asynchronous active-low reset (button reads as released)
//   btn_raw   : raw active-low button, asynchronous to clk_sys
//   level     : debounced button level (1 = released)
//   press     : one-cycle pulse on a debounced 1->0 transition
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  import controller_pkg::*;

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             sync_1;
  logic             sync_2;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any return to agreement (a bounce) restarts it.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync_1  <= 1'b1;
      sync_2  <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_1  <= btn_raw;
      sync_2  <= sync_1;
      press_q <= 1'b0;
      if (sync_2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_2;
        press_q <= ~sync_2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/controller_select_fsm.sv
// Routing-mode selector driven by next/prev push buttons.
//   clk_in       : system clock
//   reset_n_in   : asynchronous active-low reset
//   next_btn_in  : raw "next mode" button, active-low, asynchronous
//   prev_btn_in  : raw "previous mode" button, active-low, asynchronous
//   select_out   : routing mode 0..11
//   blank_out    : high while the routing mux must output OFF_CODE
//   changed_out  : one-cycle pulse on every select_out update
// Build option: define SELECT_AUTOREPEAT_EN to step repeatedly while a
// single button stays held (every REPEAT_CYCLES cycles).
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | waiting for a press event
// ST_BLANK    | mode just changed; mux blanked for BLANK_CYCLES cycles
// ST_WAIT_REL | waiting for both buttons released (or auto-repeat)
module controller_select_fsm
  import controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_CYCLES    = 1000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int INIT_MODE       = 0
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       next_btn_in,
  input  logic       prev_btn_in,
  output logic [3:0] select_out,
  output logic       blank_out,
  output logic       changed_out
);

  localparam int         BLK_W    = cnt_width(BLANK_CYCLES);
  localparam logic [3:0] INIT_SEL = (INIT_MODE < 0 || INIT_MODE > MODE_MAX) ? 4'd0 : 4'(INIT_MODE);

  logic nxt_level, nxt_press;
  logic prv_level, prv_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk_sys (clk_in),
    .rst_b   (reset_n_in),
    .btn_raw (next_btn_in),
    .level   (nxt_level),
    .press   (nxt_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev_db (
    .clk_sys (clk_in),
    .rst_b   (reset_n_in),
    .btn_raw (prev_btn_in),
    .level   (prv_level),
    .press   (prv_press)
  );

  state_t           state_q, state_nxt;
  logic [3:0]       select_q, select_nxt;
  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_nxt;
  logic             changed_q, changed_nxt;

`ifdef SELECT_AUTOREPEAT_EN
  localparam int RPT_W = cnt_width(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_nxt;
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      select_q    <= INIT_SEL;
      blank_cnt_q <= '0;
      changed_q   <= 1'b0;
`ifdef SELECT_AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_nxt;
      select_q    <= select_nxt;
      blank_cnt_q <= blank_cnt_nxt;
      changed_q   <= changed_nxt;
`ifdef SELECT_AUTOREPEAT_EN
      rpt_cnt_q   <= rpt_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state_q;
    select_nxt    = select_q;
    blank_cnt_nxt = blank_cnt_q;
    changed_nxt   = 1'b0;
`ifdef SELECT_AUTOREPEAT_EN
    rpt_cnt_nxt   = rpt_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (nxt_press && prv_press) begin
          state_nxt = ST_WAIT_REL;
`ifdef SELECT_AUTOREPEAT_EN
          rpt_cnt_nxt = RPT_LOAD;
`endif
        end else if (nxt_press || prv_press) begin
          select_nxt    = mode_step(select_q, nxt_press);
          changed_nxt   = 1'b1;
          blank_cnt_nxt = BLK_W'(BLANK_CYCLES - 1);
          state_nxt     = ST_BLANK;
        end
      end

      // Press events arriving here are dropped, not queued.
      ST_BLANK: begin
        if (blank_cnt_q == '0) begin
          state_nxt = ST_WAIT_REL;
`ifdef SELECT_AUTOREPEAT_EN
          rpt_cnt_nxt = RPT_LOAD;
`endif
        end else begin
          blank_cnt_nxt = blank_cnt_q - 1'b1;
        end
      end

      ST_WAIT_REL: begin
        if (nxt_level && prv_level) begin
          state_nxt = ST_IDLE;
        end
`ifdef SELECT_AUTOREPEAT_EN
        else if (nxt_level ^ prv_level) begin
          if (rpt_cnt_q == '0) begin
            select_nxt    = mode_step(select_q, ~nxt_level);
            changed_nxt   = 1'b1;
            blank_cnt_nxt = BLK_W'(BLANK_CYCLES - 1);
            state_nxt     = ST_BLANK;
          end else begin
            rpt_cnt_nxt = rpt_cnt_q - 1'b1;
          end
        end else begin
          rpt_cnt_nxt = RPT_LOAD;
        end
`endif
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign select_out  = select_q;
  assign blank_out   = (state_q == ST_BLANK);
  assign changed_out = changed_q;

endmodule

// File: tb/tb_controller_select_fsm.sv
module tb_controller_select_fsm;

  logic       clk_in = 1'b0;
  logic       reset_n_in;
  logic       next_btn_in;
  logic       prev_btn_in;
  logic [3:0] select_out;
  logic       blank_out;
  logic       changed_out;

  int tests = 0;
  int fails = 0;
  int chg_cnt = 0;
  int blk_cnt = 0;
  int max_sel = 0;

  controller_select_fsm #(
    .DEBOUNCE_CYCLES (4),
    .BLANK_CYCLES    (3),
    .REPEAT_CYCLES   (20),
    .INIT_MODE       (0)
  ) dut (
    .clk_in      (clk_in),
    .reset_n_in  (reset_n_in),
    .next_btn_in (next_btn_in),
    .prev_btn_in (prev_btn_in),
    .select_out  (select_out),
    .blank_out   (blank_out),
    .changed_out (changed_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit nxt;
    bit prv;
    int hold;
    int exp_sel;
    int exp_chg;
    int exp_blk;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (changed_out) chg_cnt++;
    if (blank_out) blk_cnt++;
    if (int'(select_out) > max_sel) max_sel = int'(select_out);
  endtask

  task automatic do_reset();
    next_btn_in = 1'b1;
    prev_btn_in = 1'b1;
    reset_n_in  = 1'b0;
    repeat (3) tick();
    reset_n_in = 1'b1;
    chg_cnt = 0;
    blk_cnt = 0;
  endtask

  // Drive pressed levels (1 = pressed) for hold cycles, release, let it settle.
  task automatic press_hold(input bit n, input bit p, input int hold);
    chg_cnt = 0;
    blk_cnt = 0;
    next_btn_in = ~n;
    prev_btn_in = ~p;
    repeat (hold) tick();
    next_btn_in = 1'b1;
    prev_btn_in = 1'b1;
    repeat (15) tick();
  endtask

  initial begin
    int lat;
    logic [3:0] start_sel;

    // nxt prv hold  sel chg blk
    vecs[0] = '{1, 0, 10,  1, 1, 3};
    vecs[1] = '{1, 0, 10,  2, 1, 3};
    vecs[2] = '{0, 1, 10,  1, 1, 3};
    vecs[3] = '{0, 1, 10,  0, 1, 3};
    vecs[4] = '{0, 1, 10, 11, 1, 3};
    vecs[5] = '{1, 0, 10,  0, 1, 3};
    vecs[6] = '{1, 1, 10,  0, 0, 0};
    vecs[7] = '{1, 0, 20,  1, 1, 3};

    next_btn_in = 1'b1;
    prev_btn_in = 1'b1;
    reset_n_in  = 1'b0;
    #3;
    check("reset_select", int'(select_out), 0);
    check("reset_blank", int'(blank_out), 0);
    check("reset_changed", int'(changed_out), 0);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      press_hold(vecs[i].nxt, vecs[i].prv, vecs[i].hold);
      check($sformatf("vec%0d_select", i), int'(select_out), vecs[i].exp_sel);
      check($sformatf("vec%0d_changed_pulses", i), chg_cnt, vecs[i].exp_chg);
      check($sformatf("vec%0d_blank_cycles", i), blk_cnt, vecs[i].exp_blk);
    end

    // Latency from raw press to select change: 2 sync + 4 debounce + 1.
    do_reset();
    next_btn_in = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (select_out != 4'd0) begin
        lat = k;
        break;
      end
    end
    check("press_latency", lat, 7);
    check("changed_at_step", int'(changed_out), 1);
    check("blank_at_step", int'(blank_out), 1);
    tick();
    check("changed_one_cycle", int'(changed_out), 0);
    repeat (5) tick();
    next_btn_in = 1'b1;
    repeat (15) tick();
    check("first_press_blank_cycles", blk_cnt, 3);

    // Bouncing input followed by a steady press: exactly one step.
    start_sel = select_out;
    chg_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      next_btn_in = 1'b0;
      repeat (2) tick();
      next_btn_in = 1'b1;
      repeat (2) tick();
    end
    press_hold(1, 0, 10);
    check("bounce_select", int'(select_out), int'(start_sel) + 1);
    check("bounce_changed_pulses", chg_cnt, 1);

    // prev press event lands inside the blanking window and is dropped.
    start_sel = select_out;
    chg_cnt = 0;
    blk_cnt = 0;
    next_btn_in = 1'b0;
    repeat (2) tick();
    prev_btn_in = 1'b0;
    repeat (12) tick();
    next_btn_in = 1'b1;
    prev_btn_in = 1'b1;
    repeat (15) tick();
    check("blank_ignore_select", int'(select_out), int'(start_sel) + 1);
    check("blank_ignore_changed", chg_cnt, 1);
    check("blank_ignore_blank_cycles", blk_cnt, 3);

    // Reset asserted in the middle of blanking.
    start_sel = select_out;
    next_btn_in = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (select_out != start_sel) begin
        lat = k;
        break;
      end
    end
    check("midblank_step_seen", lat, 7);
    tick();
    next_btn_in = 1'b1;
    reset_n_in = 1'b0;
    #1;
    check("midblank_reset_select", int'(select_out), 0);
    check("midblank_reset_blank", int'(blank_out), 0);
    check("midblank_reset_changed", int'(changed_out), 0);
    repeat (2) tick();
    reset_n_in = 1'b1;
    chg_cnt = 0;
    repeat (12) tick();
    check("midblank_no_pending_select", int'(select_out), 0);
    check("midblank_no_pending_changed", chg_cnt, 0);

    // Button held low across reset release: one debounced step.
    next_btn_in = 1'b0;
    reset_n_in = 1'b0;
    repeat (2) tick();
    reset_n_in = 1'b1;
    chg_cnt = 0;
    repeat (15) tick();
    next_btn_in = 1'b1;
    repeat (15) tick();
    check("held_through_reset_select", int'(select_out), 1);
    check("held_through_reset_changed", chg_cnt, 1);

    // Long hold from mode 2.
    do_reset();
    press_hold(1, 0, 10);
    press_hold(1, 0, 10);
    check("hold_start_select", int'(select_out), 2);
`ifdef SELECT_AUTOREPEAT_EN
    press_hold(1, 0, 66);
    check("long_hold_select", int'(select_out), 5);
    check("long_hold_steps", chg_cnt, 3);
`else
    press_hold(1, 0, 70);
    check("long_hold_select", int'(select_out), 3);
    check("long_hold_steps", chg_cnt, 1);
`endif

    check("select_max_seen_le_11", (max_sel <= 11) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
